// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the data-memory access controller.
//   state_e  : controller FSM states
//   size_e   : access size encodings carried on m_size / dreq_size
//   STRB_*   : base byte-strobe patterns (shifted by address offset)
//   OPC_*    : load/store major opcodes decoded upstream of this block
//   is_misaligned() : alignment rule shared by the controller
package mem_access_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_RSVD = 2'd3
  } size_e;

  localparam logic [3:0] STRB_NONE = 4'b0000;
  localparam logic [3:0] STRB_BYTE = 4'b0001;
  localparam logic [3:0] STRB_HALF = 4'b0011;
  localparam logic [3:0] STRB_WORD = 4'b1111;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  // Reserved size is handled as a word, so it carries the word rule.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic r;
    case (size)
      SZ_BYTE: r = 1'b0;
      SZ_HALF: r = addr_lo[0];
      default: r = |addr_lo;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_lane.sv
// mem_lane_align: combinational byte-lane steering for data memory.
//   i_size, i_addr_lo : latched access size and byte offset
//   i_write           : 1 = store (strobes/data active), 0 = load
//   i_wdata           : right-aligned store data
//   i_rdata           : raw word returned by memory
//   o_strobe          : byte-enable mask for the store
//   o_wdata           : store data replicated across lanes
//   o_rdata           : load data shifted down to bit 0
module mem_lane_align
  import mem_access_ctrl_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic        i_write,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_strobe,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  always_comb begin
    o_strobe = STRB_NONE;
    o_wdata  = '0;
    if (i_write) begin
      case (i_size)
        SZ_BYTE: begin
          o_strobe = STRB_BYTE << i_addr_lo;
          o_wdata  = {4{i_wdata[7:0]}};
        end
        SZ_HALF: begin
          o_strobe = STRB_HALF << i_addr_lo;
          o_wdata  = {2{i_wdata[15:0]}};
        end
        default: begin
          o_strobe = STRB_WORD;
          o_wdata  = i_wdata;
        end
      endcase
    end
  end

  // Upper bits fill with zero; sign extension happens downstream.
  assign o_rdata = i_rdata >> {i_addr_lo, 3'b000};

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: memory-stage data-memory access controller.
//   clk, reset           : clock and synchronous active-high reset
//   m_vreq/m_write/...   : memory-stage access request (size, addr, wdata)
//   m_advance            : pipeline moves a new instruction into memory stage
//   dreq_*               : request channel to data memory (valid in ADDR only)
//   dresp_*              : address accept, data return, return data
//   m_data               : right-aligned load data, non-zero only in DONE
//   mem_stall            : holds the pipeline until the access completes
//   m_misalign           : current request violates alignment, not issued
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        m_vreq,
  input  logic        m_write,
  input  logic [1:0]  m_size,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_wdata,
  input  logic        m_advance,
  output logic        dreq_valid,
  output logic [31:0] dreq_addr,
  output logic [1:0]  dreq_size,
  output logic [3:0]  dreq_strobe,
  output logic [31:0] dreq_data,
  input  logic        dresp_addr_ok,
  input  logic        dresp_data_ok,
  input  logic [31:0] dresp_data,
  output logic [31:0] m_data,
  output logic        mem_stall,
  output logic        m_misalign
);

  state_e      r_state;
  state_e      w_next_state;
  logic [31:0] r_addr;
  logic [1:0]  r_size;
  logic        r_write;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;

  logic        w_accept;
  logic        w_capture;
  logic        w_issue;
  logic [3:0]  w_strobe;
  logic [31:0] w_lane_wdata;
  logic [31:0] w_lane_rdata;

  // Outputs are gated by reset so they read as idle during the reset cycle,
  // before the synchronous state clear has taken effect.
  assign m_misalign = m_vreq & ~reset & is_misaligned(m_size, m_addr[1:0]);
  assign w_accept   = (r_state == ST_IDLE) & m_vreq & ~m_misalign;
  assign w_capture  = ((r_state == ST_ADDR) & dresp_addr_ok & dresp_data_ok) |
                      ((r_state == ST_DATA) & dresp_data_ok);
  assign w_issue    = (r_state == ST_ADDR) & ~reset;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next_state = ST_ADDR;
      ST_ADDR: begin
        if (dresp_addr_ok) begin
          w_next_state = dresp_data_ok ? ST_DONE : ST_DATA;
        end
      end
      ST_DATA: if (dresp_data_ok) w_next_state = ST_DONE;
      ST_DONE: if (m_advance) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_size  <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_addr  <= m_addr;
        r_size  <= m_size;
        r_write <= m_write;
        r_wdata <= m_wdata;
      end
      if (w_capture) begin
        r_rdata <= dresp_data;
      end
    end
  end

  mem_lane_align u_lane (
    .i_size    (r_size),
    .i_addr_lo (r_addr[1:0]),
    .i_write   (r_write),
    .i_wdata   (r_wdata),
    .i_rdata   (r_rdata),
    .o_strobe  (w_strobe),
    .o_wdata   (w_lane_wdata),
    .o_rdata   (w_lane_rdata)
  );

  assign dreq_valid  = w_issue;
  assign dreq_addr   = w_issue ? r_addr       : '0;
  assign dreq_size   = w_issue ? r_size       : '0;
  assign dreq_strobe = w_issue ? w_strobe     : '0;
  assign dreq_data   = w_issue ? w_lane_wdata : '0;

  assign m_data    = ((r_state == ST_DONE) & ~reset) ? w_lane_rdata : '0;
  assign mem_stall = m_vreq & ~m_misalign & (reset | (r_state != ST_DONE));

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  logic        clk;
  logic        reset;
  logic        m_vreq;
  logic        m_write;
  logic [1:0]  m_size;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_advance;
  logic        dreq_valid;
  logic [31:0] dreq_addr;
  logic [1:0]  dreq_size;
  logic [3:0]  dreq_strobe;
  logic [31:0] dreq_data;
  logic        dresp_addr_ok;
  logic        dresp_data_ok;
  logic [31:0] dresp_data;
  logic [31:0] m_data;
  logic        mem_stall;
  logic        m_misalign;

  int n_cmp = 0;
  int n_err = 0;

  mem_access_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .m_vreq        (m_vreq),
    .m_write       (m_write),
    .m_size        (m_size),
    .m_addr        (m_addr),
    .m_wdata       (m_wdata),
    .m_advance     (m_advance),
    .dreq_valid    (dreq_valid),
    .dreq_addr     (dreq_addr),
    .dreq_size     (dreq_size),
    .dreq_strobe   (dreq_strobe),
    .dreq_data     (dreq_data),
    .dresp_addr_ok (dresp_addr_ok),
    .dresp_data_ok (dresp_data_ok),
    .dresp_data    (dresp_data),
    .m_data        (m_data),
    .mem_stall     (mem_stall),
    .m_misalign    (m_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are changed 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic issue(input logic w, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd);
    m_vreq  = 1'b1;
    m_write = w;
    m_size  = sz;
    m_addr  = a;
    m_wdata = wd;
  endtask

  task automatic idle_inputs();
    m_vreq = 1'b0; m_write = 1'b0; m_size = 2'd0; m_addr = '0; m_wdata = '0;
    m_advance = 1'b0; dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    issue(1'b0, 2'd2, 32'h100, 32'h0);
    settle();
    n_cmp++; if (dreq_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", dreq_valid); end
    n_cmp++; if (dreq_strobe !== 4'b0) begin n_err++; $display("FAIL rst_strobe: got %b want 0000", dreq_strobe); end
    n_cmp++; if (m_data !== 32'h0) begin n_err++; $display("FAIL rst_mdata: got %h want 0", m_data); end
    n_cmp++; if (m_misalign !== 1'b0) begin n_err++; $display("FAIL rst_misalign: got %b want 0", m_misalign); end
    n_cmp++; if (mem_stall !== 1'b1) begin n_err++; $display("FAIL rst_stall: got %b want 1", mem_stall); end
    step();
    reset = 1'b0;
    idle_inputs();
    settle();
    n_cmp++; if (mem_stall !== 1'b0) begin n_err++; $display("FAIL rst_stall_idle: got %b want 0", mem_stall); end
  endtask

  task automatic test_word_load();
    issue(1'b0, 2'd2, 32'h100, 32'h0);
    settle();
    n_cmp++; if (mem_stall !== 1'b1) begin n_err++; $display("FAIL wl_stall0: got %b want 1", mem_stall); end
    n_cmp++; if (dreq_valid !== 1'b0) begin n_err++; $display("FAIL wl_valid0: got %b want 0", dreq_valid); end
    step();
    dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; dresp_data = 32'hDEADBEEF;
    settle();
    n_cmp++; if (dreq_valid !== 1'b1) begin n_err++; $display("FAIL wl_valid1: got %b want 1", dreq_valid); end
    n_cmp++; if (dreq_addr !== 32'h100) begin n_err++; $display("FAIL wl_addr: got %h want 00000100", dreq_addr); end
    n_cmp++; if (dreq_size !== 2'd2) begin n_err++; $display("FAIL wl_size: got %0d want 2", dreq_size); end
    n_cmp++; if (dreq_strobe !== 4'b0000) begin n_err++; $display("FAIL wl_strobe: got %b want 0000", dreq_strobe); end
    n_cmp++; if (mem_stall !== 1'b1) begin n_err++; $display("FAIL wl_stall1: got %b want 1", mem_stall); end
    step();
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = '0;
    settle();
    n_cmp++; if (mem_stall !== 1'b0) begin n_err++; $display("FAIL wl_stall2: got %b want 0", mem_stall); end
    n_cmp++; if (m_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL wl_mdata: got %h want deadbeef", m_data); end
    n_cmp++; if (dreq_valid !== 1'b0) begin n_err++; $display("FAIL wl_valid2: got %b want 0", dreq_valid); end
    m_advance = 1'b1;
    step();
    idle_inputs();
    settle();
    n_cmp++; if (m_data !== 32'h0) begin n_err++; $display("FAIL wl_mdata_idle: got %h want 0", m_data); end
  endtask

  task automatic test_byte_store();
    issue(1'b1, 2'd0, 32'h103, 32'h000000A5);
    step();
    dresp_addr_ok = 1'b1;
    settle();
    n_cmp++; if (dreq_strobe !== 4'b1000) begin n_err++; $display("FAIL bs_strobe: got %b want 1000", dreq_strobe); end
    n_cmp++; if (dreq_data !== 32'hA5A5A5A5) begin n_err++; $display("FAIL bs_data: got %h want a5a5a5a5", dreq_data); end
    n_cmp++; if (dreq_addr !== 32'h103) begin n_err++; $display("FAIL bs_addr: got %h want 00000103", dreq_addr); end
    step();
    dresp_addr_ok = 1'b0;
    settle();
    n_cmp++; if (dreq_valid !== 1'b0) begin n_err++; $display("FAIL bs_data_valid: got %b want 0", dreq_valid); end
    n_cmp++; if (dreq_strobe !== 4'b0000) begin n_err++; $display("FAIL bs_data_strobe: got %b want 0000", dreq_strobe); end
    n_cmp++; if (dreq_data !== 32'h0) begin n_err++; $display("FAIL bs_data_zero: got %h want 0", dreq_data); end
    n_cmp++; if (mem_stall !== 1'b1) begin n_err++; $display("FAIL bs_stall_wait: got %b want 1", mem_stall); end
    step();
    settle();
    n_cmp++; if (mem_stall !== 1'b1) begin n_err++; $display("FAIL bs_stall_wait2: got %b want 1", mem_stall); end
    dresp_data_ok = 1'b1;
    step();
    dresp_data_ok = 1'b0;
    settle();
    n_cmp++; if (mem_stall !== 1'b0) begin n_err++; $display("FAIL bs_stall_done: got %b want 0", mem_stall); end
    m_advance = 1'b1;
    step();
    idle_inputs();
  endtask

  task automatic test_half_load_wait();
    issue(1'b0, 2'd1, 32'h202, 32'h0);
    step();
    // Change the memory-stage inputs to prove the request comes from latches.
    m_addr = 32'h300; m_wdata = 32'h77777777; m_write = 1'b1;
    dresp_data = 32'hFFFFFFFF;
    for (int i = 0; i < 3; i++) begin
      m_advance = (i == 1);
      settle();
      n_cmp++; if (dreq_valid !== 1'b1) begin n_err++; $display("FAIL hl_valid[%0d]: got %b want 1", i, dreq_valid); end
      n_cmp++; if (dreq_addr !== 32'h202) begin n_err++; $display("FAIL hl_addr[%0d]: got %h want 00000202", i, dreq_addr); end
      n_cmp++; if (dreq_size !== 2'd1) begin n_err++; $display("FAIL hl_size[%0d]: got %0d want 1", i, dreq_size); end
      n_cmp++; if (dreq_strobe !== 4'b0000) begin n_err++; $display("FAIL hl_strobe[%0d]: got %b want 0000", i, dreq_strobe); end
      step();
    end
    m_advance = 1'b0;
    dresp_addr_ok = 1'b1;
    step();
    dresp_addr_ok = 1'b0;
    settle();
    n_cmp++; if (dreq_valid !== 1'b0) begin n_err++; $display("FAIL hl_data_valid: got %b want 0", dreq_valid); end
    step();
    dresp_data_ok = 1'b1; dresp_data = 32'h1234ABCD;
    step();
    dresp_data_ok = 1'b0; dresp_data = 32'hFFFFFFFF;
    settle();
    n_cmp++; if (m_data !== 32'h00001234) begin n_err++; $display("FAIL hl_mdata: got %h want 00001234", m_data); end
    n_cmp++; if (mem_stall !== 1'b0) begin n_err++; $display("FAIL hl_stall: got %b want 0", mem_stall); end
    m_advance = 1'b1;
    step();
    idle_inputs();
  endtask

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [3:0]  st;
    logic [31:0] ewd;
    logic [31:0] emd;
  } vec_t;

  task automatic test_lanes();
    vec_t tbl[6];
    tbl[0] = '{1'b1, 2'd1, 32'h102, 32'h0000BEEF, 32'h0, 4'b1100, 32'hBEEFBEEF, 32'h0};
    tbl[1] = '{1'b1, 2'd0, 32'h101, 32'h12345677, 32'h0, 4'b0010, 32'h77777777, 32'h0};
    tbl[2] = '{1'b1, 2'd2, 32'h108, 32'hA1B2C3D4, 32'h0, 4'b1111, 32'hA1B2C3D4, 32'h0};
    tbl[3] = '{1'b1, 2'd3, 32'h10C, 32'h0F0F0F0F, 32'h0, 4'b1111, 32'h0F0F0F0F, 32'h0};
    tbl[4] = '{1'b1, 2'd1, 32'h200, 32'hFFFF1234, 32'h0, 4'b0011, 32'h12341234, 32'h0};
    tbl[5] = '{1'b0, 2'd0, 32'h103, 32'h0, 32'h9A000000, 4'b0000, 32'h0, 32'h0000009A};
    for (int i = 0; i < 6; i++) begin
      issue(tbl[i].w, tbl[i].sz, tbl[i].a, tbl[i].wd);
      step();
      dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; dresp_data = tbl[i].rd;
      settle();
      n_cmp++; if (dreq_strobe !== tbl[i].st) begin n_err++; $display("FAIL lane_strobe[%0d]: got %b want %b", i, dreq_strobe, tbl[i].st); end
      n_cmp++; if (dreq_size !== tbl[i].sz) begin n_err++; $display("FAIL lane_size[%0d]: got %0d want %0d", i, dreq_size, tbl[i].sz); end
      n_cmp++; if (dreq_addr !== tbl[i].a) begin n_err++; $display("FAIL lane_addr[%0d]: got %h want %h", i, dreq_addr, tbl[i].a); end
      if (tbl[i].w) begin
        n_cmp++; if (dreq_data !== tbl[i].ewd) begin n_err++; $display("FAIL lane_wdata[%0d]: got %h want %h", i, dreq_data, tbl[i].ewd); end
      end
      step();
      dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = '0;
      settle();
      n_cmp++; if (mem_stall !== 1'b0) begin n_err++; $display("FAIL lane_stall[%0d]: got %b want 0", i, mem_stall); end
      if (!tbl[i].w) begin
        n_cmp++; if (m_data !== tbl[i].emd) begin n_err++; $display("FAIL lane_mdata[%0d]: got %h want %h", i, m_data, tbl[i].emd); end
      end
      m_advance = 1'b1;
      step();
      idle_inputs();
    end
  endtask

  task automatic test_misalign();
    issue(1'b0, 2'd2, 32'h101, 32'h0);
    settle();
    n_cmp++; if (m_misalign !== 1'b1) begin n_err++; $display("FAIL ma_word: got %b want 1", m_misalign); end
    n_cmp++; if (mem_stall !== 1'b0) begin n_err++; $display("FAIL ma_stall: got %b want 0", mem_stall); end
    step();
    settle();
    n_cmp++; if (dreq_valid !== 1'b0) begin n_err++; $display("FAIL ma_valid: got %b want 0", dreq_valid); end
    issue(1'b1, 2'd1, 32'h203, 32'h0);
    settle();
    n_cmp++; if (m_misalign !== 1'b1) begin n_err++; $display("FAIL ma_half: got %b want 1", m_misalign); end
    issue(1'b1, 2'd0, 32'h203, 32'h0);
    settle();
    n_cmp++; if (m_misalign !== 1'b0) begin n_err++; $display("FAIL ma_byte: got %b want 0", m_misalign); end
    n_cmp++; if (mem_stall !== 1'b1) begin n_err++; $display("FAIL ma_byte_stall: got %b want 1", mem_stall); end
    idle_inputs();
    step();
    settle();
    n_cmp++; if (dreq_valid !== 1'b0) begin n_err++; $display("FAIL ma_still_idle: got %b want 0", dreq_valid); end
  endtask

  task automatic test_reset_mid();
    issue(1'b0, 2'd2, 32'h100, 32'h0);
    step();
    dresp_addr_ok = 1'b1;
    step();
    dresp_addr_ok = 1'b0;
    reset = 1'b1;
    settle();
    n_cmp++; if (dreq_valid !== 1'b0) begin n_err++; $display("FAIL rm_valid: got %b want 0", dreq_valid); end
    step();
    reset = 1'b0;
    m_vreq = 1'b0;
    dresp_data_ok = 1'b1; dresp_data = 32'h55555555;
    step();
    dresp_data_ok = 1'b0;
    settle();
    n_cmp++; if (m_data !== 32'h0) begin n_err++; $display("FAIL rm_mdata: got %h want 0", m_data); end
    n_cmp++; if (dreq_valid !== 1'b0) begin n_err++; $display("FAIL rm_valid2: got %b want 0", dreq_valid); end
    m_vreq = 1'b1;
    settle();
    n_cmp++; if (mem_stall !== 1'b1) begin n_err++; $display("FAIL rm_not_done: got %b want 1", mem_stall); end
    idle_inputs();
    step();
  endtask

  task automatic test_back_to_back();
    issue(1'b0, 2'd2, 32'h400, 32'h0);
    step();
    dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; dresp_data = 32'hCAFEF00D;
    step();
    dresp_addr_ok = 1'b0;
    dresp_data = 32'h11111111;
    for (int i = 0; i < 4; i++) begin
      settle();
      n_cmp++; if (m_data !== 32'hCAFEF00D) begin n_err++; $display("FAIL bb_hold[%0d]: got %h want cafef00d", i, m_data); end
      n_cmp++; if (dreq_valid !== 1'b0) begin n_err++; $display("FAIL bb_noreq[%0d]: got %b want 0", i, dreq_valid); end
      step();
    end
    dresp_data_ok = 1'b0;
    m_advance = 1'b1;
    step();
    m_advance = 1'b0;
    issue(1'b0, 2'd2, 32'h500, 32'h0);
    settle();
    n_cmp++; if (mem_stall !== 1'b1) begin n_err++; $display("FAIL bb_stall_new: got %b want 1", mem_stall); end
    n_cmp++; if (m_data !== 32'h0) begin n_err++; $display("FAIL bb_mdata_idle: got %h want 0", m_data); end
    step();
    settle();
    n_cmp++; if (dreq_valid !== 1'b1) begin n_err++; $display("FAIL bb_newreq: got %b want 1", dreq_valid); end
    n_cmp++; if (dreq_addr !== 32'h500) begin n_err++; $display("FAIL bb_newaddr: got %h want 00000500", dreq_addr); end
    dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; dresp_data = 32'h0;
    step();
    idle_inputs();
    m_advance = 1'b1;
    step();
    idle_inputs();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    step();
    test_reset();
    test_word_load();
    test_byte_store();
    test_half_load_wait();
    test_lanes();
    test_misalign();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
